// File: rtl/tick_meter_pkg.sv
// Shared constants and types for the tick period meter.
// State encodings, error counter width and a saturating increment.
package tick_meter_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_MEAS = 2'd2;
   localparam logic [1:0] ST_LOCK = 2'd3;

   localparam int ERR_W = 8;

   typedef enum logic [1:0] {
      IDLE       = ST_IDLE,
      WAIT_FIRST = ST_WAIT,
      MEASURE    = ST_MEAS,
      LOCKED     = ST_LOCK
   } state_t;

   function automatic logic [ERR_W-1:0] err_inc(
      input logic [ERR_W-1:0] v
   );
      return (&v) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/period_cnt.sv
// Saturating loadable up-counter used to time the gap between ticks.
// sat flags the all-ones value, where the counter holds.
module period_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_b,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] cnt,
   output logic         sat
);

   localparam logic [W-1:0] ONE = W'(1);

   assign sat = &cnt;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= d;
      end else if (!sat) begin
         cnt <= cnt + ONE;
      end
   end

endmodule

// File: rtl/tick_period_meter.sv
// Measures the clk-cycle period of a divided tick and locks when it
// repeatedly matches the expected value; flags mismatches and timeouts.
module tick_period_meter
   import tick_meter_pkg::*;
#(
   parameter int W      = 8,
   parameter int EXP    = 6,
   parameter int LOCK_N = 3
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             clr,
   input  logic             en,
   input  logic             tick_in,
   output logic [W-1:0]     period,
   output logic             period_vld,
   output logic             locked,
   output logic             err,
   output logic [ERR_W-1:0] err_cnt
);

   localparam logic [W-1:0] EXP_V  = W'(EXP);
   localparam logic [3:0]   LOCK_V = 4'(LOCK_N);
   localparam logic [W-1:0] ONE    = W'(1);

   state_t         state;
   logic           tick_q;
   logic [3:0]     mcnt;
   logic [3:0]     m_inc;
   logic [W-1:0]   cnt;
   logic           sat;
   logic           rise;
   logic           hit;

   assign rise  = tick_in & ~tick_q;
   assign hit   = (cnt == EXP_V);
   assign m_inc = (mcnt >= LOCK_V) ? LOCK_V : mcnt + 4'd1;

   period_cnt #(
      .W(W)
   ) u_cnt (
      .clk   (clk),
      .rst_b (rst_b),
      .clr   (clr),
      .load  (rise),
      .d     (ONE),
      .cnt   (cnt),
      .sat   (sat)
   );

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state      <= IDLE;
         tick_q     <= 1'b0;
         mcnt       <= '0;
         period     <= '0;
         period_vld <= 1'b0;
         locked     <= 1'b0;
         err        <= 1'b0;
         err_cnt    <= '0;
      end else if (clr) begin
         state      <= IDLE;
         tick_q     <= 1'b0;
         mcnt       <= '0;
         period     <= '0;
         period_vld <= 1'b0;
         locked     <= 1'b0;
         err        <= 1'b0;
         err_cnt    <= '0;
      end else begin
         tick_q     <= tick_in;
         period_vld <= 1'b0;
         err        <= 1'b0;
         if (!en) begin
            // Disable wins over a coincident edge.
            state  <= IDLE;
            mcnt   <= '0;
            locked <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  state <= WAIT_FIRST;
               end
               WAIT_FIRST: begin
                  if (rise) state <= MEASURE;
               end
               MEASURE: begin
                  if (rise) begin
                     period     <= cnt;
                     period_vld <= 1'b1;
                     if (hit) begin
                        mcnt <= m_inc;
                        if (m_inc == LOCK_V) begin
                           state  <= LOCKED;
                           locked <= 1'b1;
                        end
                     end else begin
                        mcnt <= '0;
                     end
                  end else if (sat) begin
                     state   <= WAIT_FIRST;
                     mcnt    <= '0;
                     err     <= 1'b1;
                     err_cnt <= err_inc(err_cnt);
                  end
               end
               LOCKED: begin
                  if (rise) begin
                     period     <= cnt;
                     period_vld <= 1'b1;
                     if (hit) begin
                        mcnt <= m_inc;
                     end else begin
                        state   <= MEASURE;
                        locked  <= 1'b0;
                        mcnt    <= '0;
                        err     <= 1'b1;
                        err_cnt <= err_inc(err_cnt);
                     end
                  end else if (sat) begin
                     state   <= WAIT_FIRST;
                     locked  <= 1'b0;
                     mcnt    <= '0;
                     err     <= 1'b1;
                     err_cnt <= err_inc(err_cnt);
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tick_period_meter.sv
// Directed bench for tick_period_meter: a W=8 and a W=4 instance share
// stimulus; the W=4 one exercises the counter-saturation timeout.
module tb_tick_period_meter;

   logic       clk = 1'b0;
   logic       rst_b;
   logic       clr;
   logic       en;
   logic       tick_in;

   logic [7:0] p0;
   logic       v0, l0, e0;
   logic [7:0] ec0;
   logic [3:0] p1;
   logic       v1, l1, e1;
   logic [7:0] ec1;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   tick_period_meter #(.W(8), .EXP(6), .LOCK_N(3)) u0 (
      .clk        (clk),
      .rst_b      (rst_b),
      .clr        (clr),
      .en         (en),
      .tick_in    (tick_in),
      .period     (p0),
      .period_vld (v0),
      .locked     (l0),
      .err        (e0),
      .err_cnt    (ec0)
   );

   tick_period_meter #(.W(4), .EXP(6), .LOCK_N(3)) u1 (
      .clk        (clk),
      .rst_b      (rst_b),
      .clr        (clr),
      .en         (en),
      .tick_in    (tick_in),
      .period     (p1),
      .period_vld (v1),
      .locked     (l1),
      .err        (e1),
      .err_cnt    (ec1)
   );

   typedef struct {
      logic       tick;
      logic       en;
      logic       clr;
      logic [7:0] p;
      logic       v;
      logic       l;
      logic       e;
      logic [7:0] ec;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(logic t, logic n, logic c, logic [7:0] p,
                               logic v, logic l, logic e, logic [7:0] ec);
      vec_t r;
      r.tick = t; r.en = n; r.clr = c;
      r.p = p; r.v = v; r.l = l; r.e = e; r.ec = ec;
      tbl.push_back(r);
   endfunction

   function automatic void gap(int n, logic [7:0] p, logic l, logic [7:0] ec);
      for (int i = 0; i < n; i++) add(1'b0, 1'b1, 1'b0, p, 1'b0, l, 1'b0, ec);
   endfunction

   function automatic void hold(logic [7:0] p, logic l, logic [7:0] ec);
      for (int i = 0; i < 2; i++) add(1'b1, 1'b1, 1'b0, p, 1'b0, l, 1'b0, ec);
      gap(3, p, l, ec);
   endfunction

   task automatic chk(string nm, logic [7:0] ap, logic av, logic al,
                      logic ae, logic [7:0] aec, logic [7:0] xp, logic xv,
                      logic xl, logic xe, logic [7:0] xec);
      nvec++;
      if (ap !== xp || av !== xv || al !== xl || ae !== xe || aec !== xec) begin
         nerr++;
         $display("FAIL %s: got p=%0d vld=%b lock=%b err=%b ec=%0d, want p=%0d vld=%b lock=%b err=%b ec=%0d",
                  nm, ap, av, al, ae, aec, xp, xv, xl, xe, xec);
      end
   endtask

   task automatic chk1(string nm, int act, int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   task automatic step(logic t, logic n, logic c);
      @(negedge clk);
      tick_in = t; en = n; clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic period6();
      step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      int first;
      int npulse;
      int e0n;

      // Lock, mismatch-while-locked, relock.
      add(0,1,0, 0,0,0,0,0);
      add(1,1,0, 0,0,0,0,0); gap(5, 0,0,0);
      add(1,1,0, 6,1,0,0,0); gap(5, 6,0,0);
      add(1,1,0, 6,1,0,0,0); gap(5, 6,0,0);
      add(1,1,0, 6,1,1,0,0); gap(5, 6,1,0);
      add(1,1,0, 6,1,1,0,0); gap(4, 6,1,0);
      add(1,1,0, 5,1,0,1,1); gap(5, 5,0,1);
      add(1,1,0, 6,1,0,0,1); gap(5, 6,0,1);
      add(1,1,0, 6,1,0,0,1); gap(5, 6,0,1);
      add(1,1,0, 6,1,1,0,1); gap(5, 6,1,1);
      // Second mismatch to reach err_cnt=2, relock, then clr.
      add(1,1,0, 6,1,1,0,1); gap(4, 6,1,1);
      add(1,1,0, 5,1,0,1,2); gap(5, 5,0,2);
      add(1,1,0, 6,1,0,0,2); gap(5, 6,0,2);
      add(1,1,0, 6,1,0,0,2); gap(5, 6,0,2);
      add(1,1,0, 6,1,1,0,2); gap(2, 6,1,2);
      add(0,1,1, 0,0,0,0,0);
      // Held tick: high 3 cycles out of 6.
      add(0,1,0, 0,0,0,0,0);
      add(1,1,0, 0,0,0,0,0); hold(0,0,0);
      add(1,1,0, 6,1,0,0,0); hold(6,0,0);
      add(1,1,0, 6,1,0,0,0); hold(6,0,0);
      add(1,1,0, 6,1,1,0,0); hold(6,1,0);
      add(1,1,0, 6,1,1,0,0); hold(6,1,0);
      // en drops on an edge: no update, back through IDLE.
      add(1,0,0, 6,0,0,0,0);
      add(0,1,0, 6,0,0,0,0);
      add(1,1,0, 6,0,0,0,0); gap(5, 6,0,0);
      add(1,1,0, 6,1,0,0,0);

      rst_b = 1'b0; clr = 1'b0; en = 1'b0; tick_in = 1'b0;
      #12;
      chk("reset_u0", p0, v0, l0, e0, ec0, 0,0,0,0,0);
      chk("reset_u1", {4'd0, p1}, v1, l1, e1, ec1, 0,0,0,0,0);
      @(negedge clk);
      rst_b = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].tick, tbl[i].en, tbl[i].clr);
         chk($sformatf("vec%0d_u0", i), p0, v0, l0, e0, ec0,
             tbl[i].p, tbl[i].v, tbl[i].l, tbl[i].e, tbl[i].ec);
         chk($sformatf("vec%0d_u1", i), {4'd0, p1}, v1, l1, e1, ec1,
             tbl[i].p, tbl[i].v, tbl[i].l, tbl[i].e, tbl[i].ec);
      end

      // Timeout on the W=4 instance after losing ticks while locked.
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) period6();
      chk1("to_locked_u0", int'(l0), 1);
      chk1("to_locked_u1", int'(l1), 1);
      first = -1; npulse = 0; e0n = 0;
      for (int k = 6; k < 40; k++) begin
         step(1'b0, 1'b1, 1'b0);
         if (e1) begin
            npulse++;
            if (first < 0) first = k;
         end
         if (e0) e0n++;
      end
      chk1("to_err_cycle", first, 15);
      chk1("to_err_pulses", npulse, 1);
      chk1("to_u0_no_err", e0n, 0);
      chk1("to_unlocked", int'(l1), 0);
      chk1("to_err_cnt", int'(ec1), 1);
      chk1("to_u0_still_locked", int'(l0), 1);
      step(1'b1, 1'b1, 1'b0);
      chk1("to_first_edge_vld", int'(v1), 0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk1("to_second_edge_vld", int'(v1), 1);
      chk1("to_second_edge_p", int'(p1), 6);

      // Async reset mid-period.
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      #2;
      rst_b = 1'b0;
      #1;
      chk("arst_u0", p0, v0, l0, e0, ec0, 0,0,0,0,0);
      chk("arst_u1", {4'd0, p1}, v1, l1, e1, ec1, 0,0,0,0,0);
      @(negedge clk);
      rst_b = 1'b1;
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk("arst_first_u0", p0, v0, l0, e0, ec0, 0,0,0,0,0);
      chk("arst_first_u1", {4'd0, p1}, v1, l1, e1, ec1, 0,0,0,0,0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk("arst_second_u0", p0, v0, l0, e0, ec0, 6,1,0,0,0);
      chk("arst_second_u1", {4'd0, p1}, v1, l1, e1, ec1, 6,1,0,0,0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
